// File: rtl/imm_extend_stage.sv
// Purpose: extracts and sign-extends the I/S/B/U/J immediate to XLEN, carries a sideband tag.
// Latency: 1 cycle; 2-entry output/skid buffer sustains one entry per cycle.
// Backpressure: in_ready is registered (low only when both entries are held), never combinational on out_ready.
// Optional: define IMM_ZIMM_CSR_EN to accept ImmSrc 101 (zero-extended CSR zimm from instr[19:15]).
module imm_extend_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        ImmSrc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ImmOp,
    output logic [TAG_W-1:0]  out_tag,
    output logic              imm_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t      state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;
    logic [31:0] imm32;
    logic        illegal;
    logic        in_fire;
    logic        out_fire;

    // Opcode bits carry no immediate information.
    logic        unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Immediate extraction: build a 32-bit value, then sign-extend it to XLEN.
    // Zimm has bit 31 clear, so the same extension zero-extends it.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (ImmSrc)
            3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm32 = {instr[31:12], 12'b0};
            3'b100: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_ZIMM_CSR_EN
            3'b101: imm32 = {27'b0, instr[19:15]};
`else
            3'b101: illegal = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
        new_entry.imm     = XLEN'($signed(imm32));
        new_entry.tag     = in_tag;
        new_entry.illegal = illegal;
    end

    // Next state and data-register loads; flush overrides every transition.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    out_d   = new_entry;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    out_d = new_entry;
                end else if (in_fire) begin
                    state_d = ST_TWO;
                    skid_d  = new_entry;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Handshake and presented data come straight from registers.
    always_comb begin
        in_ready    = (state_q != ST_TWO);
        out_valid   = (state_q != ST_EMPTY);
        ImmOp       = out_q.imm;
        out_tag     = out_q.tag;
        imm_illegal = out_q.illegal;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and skid data registers; cleared on reset so outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed-vector bench for imm_extend_stage (XLEN=32 and XLEN=64 instances share inputs).
module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic [31:0] in_tag;

    logic        in_ready, out_valid, imm_illegal;
    logic [31:0] ImmOp, out_tag;
    logic        in_ready64, out_valid64, imm_illegal64;
    logic [63:0] ImmOp64;
    logic [31:0] out_tag64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_extend_stage #(.XLEN(32), .TAG_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ImmOp(ImmOp), .out_tag(out_tag), .imm_illegal(imm_illegal)
    );

    imm_extend_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .ImmOp(ImmOp64), .out_tag(out_tag64), .imm_illegal(imm_illegal64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One entry through an unstalled stage; it is presented one edge after acceptance.
    task automatic vec(input string name, input logic [31:0] i, input logic [2:0] s,
                       input logic [31:0] t, input logic [31:0] e32, input logic [63:0] e64,
                       input logic e_ill);
        @(negedge clk);
        in_valid = 1'b1; instr = i; ImmSrc = s; in_tag = t; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({name, "_vld"},   {63'b0, out_valid},   64'd1);
        check({name, "_imm"},   {32'b0, ImmOp},       {32'b0, e32});
        check({name, "_ill"},   {63'b0, imm_illegal}, {63'b0, e_ill});
        check({name, "_tag"},   {32'b0, out_tag},     {32'b0, t});
        check({name, "_vld64"}, {63'b0, out_valid64}, 64'd1);
        check({name, "_imm64"}, ImmOp64,              e64);
        check({name, "_ill64"}, {63'b0, imm_illegal64}, {63'b0, e_ill});
        check({name, "_tag64"}, {32'b0, out_tag64},   {32'b0, t});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; ImmSrc = '0; in_tag = '0;
        #2;
        check("rst_vld",   {63'b0, out_valid}, 64'd0);
        check("rst_rdy",   {63'b0, in_ready},  64'd1);
        check("rst_rdy64", {63'b0, in_ready64}, 64'd1);
        check("rst_imm",   {32'b0, ImmOp},     64'd0);
        check("rst_tag",   {32'b0, out_tag},   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Immediate formats, each with a hand-decoded expected value.
        vec("I_neg", 32'hFFF00093, 3'b000, 32'd11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        vec("I_pos", 32'h00500093, 3'b000, 32'd12, 32'h00000005, 64'h0000000000000005, 1'b0);
        vec("S",     32'hFE512E23, 3'b001, 32'd13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        vec("B",     32'hFE000CE3, 3'b010, 32'd14, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        vec("U",     32'h123450B7, 3'b011, 32'd15, 32'h12345000, 64'h0000000012345000, 1'b0);
        vec("J",     32'hFFDFF0EF, 3'b100, 32'd16, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
`ifdef IMM_ZIMM_CSR_EN
        vec("ZIMM",  32'h0002D073, 3'b101, 32'd17, 32'h00000005, 64'h0000000000000005, 1'b0);
`else
        vec("ZIMM",  32'h0002D073, 3'b101, 32'd17, 32'h00000000, 64'h0000000000000000, 1'b1);
`endif
        vec("ILL6",  32'hFFF00093, 3'b110, 32'd18, 32'h00000000, 64'h0000000000000000, 1'b1);
        vec("ILL7",  32'hFFFFFFFF, 3'b111, 32'd19, 32'h00000000, 64'h0000000000000000, 1'b1);
        step();
        check("drain_vld", {63'b0, out_valid}, 64'd0);

        // Backpressure: tags 1,2,3 with the sink stalled, then released.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; ImmSrc = 3'b000; in_tag = 32'd1;
        step();
        check("bp1_rdy", {63'b0, in_ready}, 64'd1);
        check("bp1_tag", {32'b0, out_tag},  64'd1);
        @(negedge clk);
        instr = 32'h123450B7; ImmSrc = 3'b011; in_tag = 32'd2;
        step();
        check("bp2_rdy", {63'b0, in_ready}, 64'd0);
        check("bp2_tag", {32'b0, out_tag},  64'd1);
        check("bp2_imm", {32'b0, ImmOp},    64'd5);
        @(negedge clk);
        instr = 32'hFFF00093; ImmSrc = 3'b000; in_tag = 32'd3;
        step();
        check("bp3_rdy",  {63'b0, in_ready}, 64'd0);
        check("bp3_hold", {32'b0, out_tag},  64'd1);
        check("bp3_imm",  {32'b0, ImmOp},    64'd5);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        check("bp_out2_tag", {32'b0, out_tag}, 64'd2);
        check("bp_out2_imm", {32'b0, ImmOp},   64'h12345000);
        check("bp_out2_rdy", {63'b0, in_ready}, 64'd1);
        step();
        check("bp_out3_tag", {32'b0, out_tag}, 64'd3);
        check("bp_out3_imm", {32'b0, ImmOp},   64'hFFFFFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        step();
        check("bp_end_vld", {63'b0, out_valid}, 64'd0);

        // Flush while both entries are held, with a new entry offered.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; ImmSrc = 3'b000; in_tag = 32'd4;
        step();
        @(negedge clk);
        in_tag = 32'd5;
        step();
        check("fl_two_rdy", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        in_tag = 32'd6; flush = 1'b1;
        step();
        check("fl_vld", {63'b0, out_valid}, 64'd0);
        check("fl_rdy", {63'b0, in_ready},  64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_no_stale", {63'b0, out_valid}, 64'd0);
        end

        // Flush in ONE drops the same-cycle accepted entry.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd7;
        step();
        @(negedge clk);
        in_tag = 32'd8; flush = 1'b1;
        step();
        check("fl1_vld", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl1_after", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset while an entry is presented.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; ImmSrc = 3'b000; in_tag = 32'd9;
        step();
        check("ar_pre_vld", {63'b0, out_valid}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("ar_vld", {63'b0, out_valid},   64'd0);
        check("ar_imm", {32'b0, ImmOp},       64'd0);
        check("ar_tag", {32'b0, out_tag},     64'd0);
        check("ar_ill", {63'b0, imm_illegal}, 64'd0);
        check("ar_imm64", ImmOp64,            64'd0);
        @(negedge clk);
        rst = 1'b0;
        vec("post_rst", 32'h123450B7, 3'b011, 32'd10, 32'h12345000, 64'h0000000012345000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
